// File: rtl/alu_seq_pkg.sv
// Shared types, function codes and helpers for the alu_seq front end.
// alu_golden is only referenced when ALU_SEQ_CHECK_EN is defined.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FN_W   = 5;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned CNT_W  = 4;

  localparam logic [FN_W-1:0] FN_ZERO = 5'd0;
  localparam logic [FN_W-1:0] FN_ONE  = 5'd1;
  localparam logic [FN_W-1:0] FN_NEG1 = 5'd2;
  localparam logic [FN_W-1:0] FN_X    = 5'd3;
  localparam logic [FN_W-1:0] FN_Y    = 5'd4;
  localparam logic [FN_W-1:0] FN_NOTX = 5'd5;
  localparam logic [FN_W-1:0] FN_NOTY = 5'd6;
  localparam logic [FN_W-1:0] FN_NEGX = 5'd7;
  localparam logic [FN_W-1:0] FN_NEGY = 5'd8;
  localparam logic [FN_W-1:0] FN_XP1  = 5'd9;
  localparam logic [FN_W-1:0] FN_YP1  = 5'd10;
  localparam logic [FN_W-1:0] FN_XM1  = 5'd11;
  localparam logic [FN_W-1:0] FN_YM1  = 5'd12;
  localparam logic [FN_W-1:0] FN_ADD  = 5'd13;
  localparam logic [FN_W-1:0] FN_SUB  = 5'd14;
  localparam logic [FN_W-1:0] FN_RSUB = 5'd15;
  localparam logic [FN_W-1:0] FN_AND  = 5'd16;
  localparam logic [FN_W-1:0] FN_OR   = 5'd17;
  localparam logic [FN_W-1:0] FN_LAST = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zr;
    logic              ng;
  } alu_rsp_t;

  // Table is written in zx,nx,zy,ny,f,no order (MSB first) and bit-reversed so op[0]=zx.
  function automatic logic [OP_W-1:0] fn_encode(input logic [FN_W-1:0] fn);
    logic [OP_W-1:0] c;
    case (fn)
      FN_ZERO: c = 6'b101010;
      FN_ONE:  c = 6'b111111;
      FN_NEG1: c = 6'b111010;
      FN_X:    c = 6'b001100;
      FN_Y:    c = 6'b110000;
      FN_NOTX: c = 6'b001101;
      FN_NOTY: c = 6'b110001;
      FN_NEGX: c = 6'b001111;
      FN_NEGY: c = 6'b110011;
      FN_XP1:  c = 6'b011111;
      FN_YP1:  c = 6'b110111;
      FN_XM1:  c = 6'b001110;
      FN_YM1:  c = 6'b110010;
      FN_ADD:  c = 6'b000010;
      FN_SUB:  c = 6'b010011;
      FN_RSUB: c = 6'b000111;
      FN_AND:  c = 6'b000000;
      FN_OR:   c = 6'b010101;
      default: c = 6'b000000;
    endcase
    return {c[0], c[1], c[2], c[3], c[4], c[5]};
  endfunction

  // Reference result computed from the mnemonic, independent of the control word.
  function automatic alu_rsp_t alu_golden(input logic [DATA_W-1:0] x,
                                          input logic [DATA_W-1:0] y,
                                          input logic [FN_W-1:0]   fn);
    alu_rsp_t          r;
    logic [DATA_W-1:0] v;
    case (fn)
      FN_ZERO: v = '0;
      FN_ONE:  v = DATA_W'(1);
      FN_NEG1: v = '1;
      FN_X:    v = x;
      FN_Y:    v = y;
      FN_NOTX: v = ~x;
      FN_NOTY: v = ~y;
      FN_NEGX: v = DATA_W'(0) - x;
      FN_NEGY: v = DATA_W'(0) - y;
      FN_XP1:  v = x + DATA_W'(1);
      FN_YP1:  v = y + DATA_W'(1);
      FN_XM1:  v = x - DATA_W'(1);
      FN_YM1:  v = y - DATA_W'(1);
      FN_ADD:  v = x + y;
      FN_SUB:  v = x - y;
      FN_RSUB: v = y - x;
      FN_AND:  v = x & y;
      FN_OR:   v = x | y;
      default: v = '0;
    endcase
    r.result = v;
    r.zr     = (v == '0);
    r.ng     = v[DATA_W-1];
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_op_encoder.sv
// Combinational function-code to Hack ALU control-word decoder.
// Flags codes above FN_LAST as illegal and drives an all-zero word for them.
module alu_op_encoder
  import alu_seq_pkg::*;
(
  input  logic [4:0] fn,
  output logic       illegal_c,
  output logic [5:0] op_c
);

  assign illegal_c = (fn > FN_LAST);
  assign op_c      = illegal_c ? 6'b000000 : fn_encode(fn);

endmodule

// File: rtl/alu_seq.sv
// Sequential request/response wrapper around the combinational Hack ALU.
// Define ALU_SEQ_CHECK_EN to build the golden-model checker behind rsp_mismatch.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_fn,
  input  logic [15:0] req_x,
  input  logic [15:0] req_y,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_zr,
  output logic        rsp_ng,
  output logic        rsp_illegal,
  output logic        rsp_mismatch
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             illegal_c;
  logic [OP_W-1:0]  op_c;
  logic             capture_c;

  alu_op_encoder u_enc (
    .fn        (req_fn),
    .illegal_c (illegal_c),
    .op_c      (op_c)
  );

  assign capture_c = (state == ST_DRIVE) && (cnt == CNT_W'(1));

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      alu_x       <= '0;
      alu_y       <= '0;
      alu_op      <= '0;
      rsp_result  <= '0;
      rsp_zr      <= 1'b0;
      rsp_ng      <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (illegal_c) begin
              rsp_result  <= '0;
              rsp_zr      <= 1'b0;
              rsp_ng      <= 1'b0;
              rsp_illegal <= 1'b1;
              rsp_valid   <= 1'b1;
              state       <= ST_RESP;
            end else begin
              alu_x  <= req_x;
              alu_y  <= req_y;
              alu_op <= op_c;
              cnt    <= CNT_W'(SETTLE);
              state  <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          cnt <= cnt - CNT_W'(1);
          if (capture_c) begin
            rsp_result  <= alu_result;
            rsp_zr      <= alu_zr;
            rsp_ng      <= alu_ng;
            rsp_illegal <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  logic [FN_W-1:0] fn_q;
  alu_rsp_t        exp_c;

  assign exp_c = alu_golden(alu_x, alu_y, fn_q);

  // Compare the captured ALU outputs against the mnemonic reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fn_q         <= '0;
      rsp_mismatch <= 1'b0;
    end else begin
      if (state == ST_IDLE && req_valid && !illegal_c) begin
        fn_q <= req_fn;
      end
      if (capture_c) begin
        rsp_mismatch <= ({alu_result, alu_zr, alu_ng} != exp_c);
      end else if (state == ST_RESP && rsp_ready) begin
        rsp_mismatch <= 1'b0;
      end
    end
  end
`else
  assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: SETTLE=1 and SETTLE=3 instances, each driving a behavioural Hack ALU.
// Define ALU_SEQ_CHECK_EN consistently for bench and RTL to exercise rsp_mismatch.
module tb_alu_seq;

  typedef struct packed {
    logic [15:0] res;
    logic        zr;
    logic        ng;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [4:0]  fn;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] res;
    logic        zr;
    logic        ng;
    logic        ill;
    logic        op_chk;
    logic [5:0]  op;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic [4:0]  req_fn      [2];
  logic [15:0] req_x       [2];
  logic [15:0] req_y       [2];
  logic [15:0] alu_x       [2];
  logic [15:0] alu_y       [2];
  logic [5:0]  alu_op      [2];
  logic [15:0] alu_result  [2];
  logic        alu_zr      [2];
  logic        alu_ng      [2];
  logic        rsp_valid   [2];
  logic        rsp_ready   [2];
  logic [15:0] rsp_result  [2];
  logic        rsp_zr      [2];
  logic        rsp_ng      [2];
  logic        rsp_illegal [2];
  logic        rsp_mismatch[2];
  logic        force_bad;
  logic [15:0] force_val;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_seq #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_fn(req_fn[0]),
    .req_x(req_x[0]), .req_y(req_y[0]),
    .alu_x(alu_x[0]), .alu_y(alu_y[0]), .alu_op(alu_op[0]),
    .alu_result(alu_result[0]), .alu_zr(alu_zr[0]), .alu_ng(alu_ng[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
    .rsp_zr(rsp_zr[0]), .rsp_ng(rsp_ng[0]), .rsp_illegal(rsp_illegal[0]),
    .rsp_mismatch(rsp_mismatch[0])
  );

  alu_seq #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_fn(req_fn[1]),
    .req_x(req_x[1]), .req_y(req_y[1]),
    .alu_x(alu_x[1]), .alu_y(alu_y[1]), .alu_op(alu_op[1]),
    .alu_result(alu_result[1]), .alu_zr(alu_zr[1]), .alu_ng(alu_ng[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
    .rsp_zr(rsp_zr[1]), .rsp_ng(rsp_ng[1]), .rsp_illegal(rsp_illegal[1]),
    .rsp_mismatch(rsp_mismatch[1])
  );

  // Combinational Hack ALU driven by the control word (op[0]=zx .. op[5]=no).
  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] a, b, o;
    a = c[0] ? 16'h0 : x;
    if (c[1]) a = ~a;
    b = c[2] ? 16'h0 : y;
    if (c[3]) b = ~b;
    o = c[4] ? (a + b) : (a & b);
    if (c[5]) o = ~o;
    return o;
  endfunction

  assign alu_result[0] = force_bad ? force_val : hack_alu(alu_x[0], alu_y[0], alu_op[0]);
  assign alu_result[1] = hack_alu(alu_x[1], alu_y[1], alu_op[1]);
  assign alu_zr[0] = (alu_result[0] == 16'h0);
  assign alu_ng[0] = alu_result[0][15];
  assign alu_zr[1] = (alu_result[1] == 16'h0);
  assign alu_ng[1] = alu_result[1][15];

  // Expected response from the mnemonic's arithmetic meaning.
  function automatic exp_t model(input logic [4:0] fn, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    int   v;
    e.ill = 1'b0;
    case (int'(fn))
      0: v = 0;           1: v = 1;           2: v = -1;
      3: v = int'(x);     4: v = int'(y);     5: v = ~int'(x);
      6: v = ~int'(y);    7: v = -int'(x);    8: v = -int'(y);
      9: v = int'(x) + 1; 10: v = int'(y) + 1; 11: v = int'(x) - 1;
      12: v = int'(y) - 1; 13: v = int'(x) + int'(y); 14: v = int'(x) - int'(y);
      15: v = int'(y) - int'(x); 16: v = int'(x & y); 17: v = int'(x | y);
      default: begin v = 0; e.ill = 1'b1; end
    endcase
    e.res = 16'(v);
    e.zr  = !e.ill && (e.res == 16'h0);
    e.ng  = !e.ill && e.res[15];
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One full transaction on instance k; hold = cycles rsp_ready stays low after rsp_valid.
  task automatic run_op(input int k, input logic [4:0] fn, input logic [15:0] x,
                        input logic [15:0] y, input int hold, input exp_t e,
                        input logic exp_mm, input logic op_chk, input logic [5:0] op_exp);
    int         n, lat, s;
    logic       acc;
    logic [5:0] op_before;
    s = (k == 0) ? 1 : 3;
    op_before = alu_op[k];
    req_fn[k] = fn; req_x[k] = x; req_y[k] = y;
    req_valid[k] = 1'b1; rsp_ready[k] = 1'b0;
    n = 0; acc = 1'b0;
    while (!acc && n < 20) begin
      acc = req_ready[k];
      @(posedge clk); #1;
      n++;
    end
    req_valid[k] = 1'b0;
    chk("accept", 32'(acc), 32'd1);
    if (!acc) return;
    if (e.ill) chk("illegal alu_op held", 32'(alu_op[k]), 32'(op_before));
    else begin
      chk("alu_x", 32'(alu_x[k]), 32'(x));
      chk("alu_y", 32'(alu_y[k]), 32'(y));
      if (op_chk) chk("alu_op", 32'(alu_op[k]), 32'(op_exp));
    end
    lat = 0;
    while (!rsp_valid[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), e.ill ? 32'd0 : 32'(s));
    chk("result", 32'(rsp_result[k]), 32'(e.res));
    chk("zr", 32'(rsp_zr[k]), 32'(e.zr));
    chk("ng", 32'(rsp_ng[k]), 32'(e.ng));
    chk("illegal", 32'(rsp_illegal[k]), 32'(e.ill));
    chk("mismatch", 32'(rsp_mismatch[k]), 32'(exp_mm));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold valid", 32'(rsp_valid[k]), 32'd1);
      chk("hold req_ready", 32'(req_ready[k]), 32'd0);
      chk("hold rsp", 32'({rsp_result[k], rsp_zr[k], rsp_ng[k], rsp_illegal[k]}),
          32'({e.res, e.zr, e.ng, e.ill}));
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
    chk("post-handshake rsp_valid", 32'(rsp_valid[k]), 32'd0);
    chk("post-handshake req_ready", 32'(req_ready[k]), 32'd1);
  endtask

  vec_t vt[12];

  initial begin
    exp_t        e;
    int          k, n;
    logic [4:0]  fn;
    logic [15:0] x, y;

    vt[0]  = '{5'd13, 16'd1, 16'd1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1, 6'b010000};
    vt[1]  = '{5'd14, 16'd1, 16'd1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 6'b110010};
    vt[2]  = '{5'd2, 16'd1, 16'd1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0};
    vt[3]  = '{5'd7, 16'd1, 16'd1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0};
    vt[4]  = '{5'd20, 16'd1, 16'd1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b0};
    vt[5]  = '{5'd17, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0};
    vt[6]  = '{5'd15, 16'd3, 16'd10, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0};
    vt[7]  = '{5'd8, 16'd0, 16'd1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0};
    vt[8]  = '{5'd16, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0};
    vt[9]  = '{5'd11, 16'd0, 16'd5, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0};
    vt[10] = '{5'd9, 16'hFFFF, 16'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b0};
    vt[11] = '{5'd31, 16'd5, 16'd5, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b0};

    rst = 1'b1; force_bad = 1'b0; force_val = 16'h0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; rsp_ready[i] = 1'b0;
      req_fn[i] = 5'd0; req_x[i] = 16'h0; req_y[i] = 16'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset req_ready", 32'(req_ready[i]), 32'd1);
      chk("reset rsp_valid", 32'(rsp_valid[i]), 32'd0);
      chk("reset alu_op", 32'(alu_op[i]), 32'd0);
      chk("reset outputs", 32'({alu_x[i], rsp_result[i]}), 32'd0);
    end
    rst = 1'b0;

    // Directed table on the SETTLE=1 instance.
    for (int i = 0; i < 12; i++) begin
      e = '{vt[i].res, vt[i].zr, vt[i].ng, vt[i].ill};
      run_op(0, vt[i].fn, vt[i].x, vt[i].y, 0, e, 1'b0, vt[i].op_chk, vt[i].op);
    end

    // SETTLE=3: OR with consumer stalling for 4 cycles.
    e = '{16'h0FF0, 1'b0, 1'b0, 1'b0};
    run_op(1, 5'd17, 16'h00F0, 16'h0F00, 4, e, 1'b0, 1'b0, 6'b0);

    // Asynchronous reset while the SETTLE=3 instance is in DRIVE.
    req_fn[1] = 5'd13; req_x[1] = 16'h1234; req_y[1] = 16'h0101; req_valid[1] = 1'b1;
    n = 0;
    while (!req_ready[1] && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("pre-reset busy", 32'(req_ready[1]), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid-op reset req_ready", 32'(req_ready[1]), 32'd1);
    chk("mid-op reset rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("mid-op reset alu", 32'({alu_x[1], alu_y[1]}), 32'd0);
    chk("mid-op reset alu_op", 32'(alu_op[1]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("no response after reset", 32'(rsp_valid[1]), 32'd0);
    end
    e = model(5'd13, 16'h1234, 16'h0101);
    run_op(1, 5'd13, 16'h1234, 16'h0101, 0, e, 1'b0, 1'b0, 6'b0);

    // Randomized traffic against the mnemonic model on both instances.
    for (int i = 0; i < 60; i++) begin
      k  = i % 2;
      fn = 5'($urandom_range(0, 20));
      x  = 16'($urandom);
      y  = 16'($urandom);
      if (i % 7 == 0) y = x;
      e = model(fn, x, y);
      run_op(k, fn, x, y, int'($urandom_range(0, 2)), e, 1'b0, 1'b0, 6'b0);
    end

    // Broken ALU output: fn=0 captures 5.
    force_bad = 1'b1; force_val = 16'd5;
    e = '{16'd5, 1'b0, 1'b0, 1'b0};
`ifdef ALU_SEQ_CHECK_EN
    run_op(0, 5'd0, 16'h1111, 16'h2222, 1, e, 1'b1, 1'b0, 6'b0);
`else
    run_op(0, 5'd0, 16'h1111, 16'h2222, 1, e, 1'b0, 1'b0, 6'b0);
`endif
    force_bad = 1'b0;
    chk("mismatch cleared", 32'(rsp_mismatch[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
